// File: rtl/regread_pkg.sv
// Shared types for the register-read stage and its neighbours.
//   XLEN          : datapath width
//   OPSZ          : operation ID space (power of two)
//   iss_bundle_t  : issued micro-op, valid = opid[15]
//   exe_bundle_t  : writeback, valid = opid[15], carries prda/res
//   red_bundle_t  : redirect, valid = opid[15], carries opid/topid
//   rr_bundle_t   : issued micro-op plus operand values and opb readiness
//   succeed()     : true when x is younger than the redirecting op
package regread_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned OPSZ = 64;
  localparam int unsigned TAGW = 8;

  typedef struct packed {
    logic [15:0]           opid;
    logic [7:0]            uop;
    logic [1:0][TAGW-1:0]  prsa;
    logic [1:0]            prsb;
    logic [TAGW-1:0]       prda;
  } iss_bundle_t;

  typedef struct packed {
    logic [15:0]      opid;
    logic [TAGW-1:0]  prda;
    logic [XLEN-1:0]  res;
  } exe_bundle_t;

  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] topid;
  } red_bundle_t;

  typedef struct packed {
    logic [15:0]           opid;
    logic [7:0]            uop;
    logic [1:0][TAGW-1:0]  prsa;
    logic [1:0]            prsb;
    logic [TAGW-1:0]       prda;
    logic [XLEN-1:0]       opa;
    logic [XLEN-1:0]       opb;
    logic                  opb_ok;
  } rr_bundle_t;

  // Age compare relative to the oldest in-flight op (topid), wrapping modulo n.
  function automatic logic succeed(red_bundle_t red, logic [15:0] x, int unsigned n = OPSZ);
    logic [15:0] m;
    logic [15:0] dx;
    logic [15:0] dr;
    m  = 16'(n - 1);
    dx = (x - red.topid) & m;
    dr = (red.opid - red.topid + 16'd1) & m;
    return red.opid[15] && x[15] && (dx >= dr);
  endfunction

endpackage

// File: rtl/regread_prf.sv
// Multi-port physical register file.
//   clk, rst : clock, asynchronous active-low reset (clears all entries)
//   raddr    : nrd read addresses; rdata returns combinationally
//   we/waddr/wdata : nwr write ports, applied at the clock edge
// Reads see same-cycle writes (highest write port wins); entry 0 reads zero
// and ignores writes.
module regread_prf #(
  parameter int unsigned nrd   = 8,
  parameter int unsigned nwr   = 4,
  parameter int unsigned depth = 128,
  parameter int unsigned width = 64,
  localparam int unsigned aw   = $clog2(depth)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [nrd-1:0][aw-1:0]     raddr,
  output logic [nrd-1:0][width-1:0]  rdata,
  input  logic [nwr-1:0]             we,
  input  logic [nwr-1:0][aw-1:0]     waddr,
  input  logic [nwr-1:0][width-1:0]  wdata
);

  logic [width-1:0] mem_q [depth];

  // Ascending port order: the last non-blocking write (highest port) wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < int'(depth); e++) mem_q[e] <= '0;
    end else begin
      for (int w = 0; w < int'(nwr); w++) begin
        if (we[w] && (waddr[w] != '0)) mem_q[waddr[w]] <= wdata[w];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int r = 0; r < int'(nrd); r++) begin
      if (raddr[r] != '0) begin
        rdata[r] = mem_q[raddr[r]];
        for (int w = 0; w < int'(nwr); w++) begin
          if (we[w] && (waddr[w] == raddr[r])) rdata[r] = wdata[w];
        end
      end
    end
  end

endmodule

// File: rtl/regread.sv
// Register-read stage between the issue queue and the function units.
//   clk, rst   : clock, asynchronous active-low reset
//   iss_bundle : issued micro-ops, one per lane
//   issue      : per-lane back-pressure to the issue queue
//   exe_bundle : writebacks (written to the register file and bypassed)
//   red_bundle : redirect; squashes younger ops
//   fu_accept  : per-lane FU consume strobe
//   rr_bundle  : per-lane pipeline register with operand values
module regread
  import regread_pkg::*;
#(
  parameter int unsigned iwd  = 4,
  parameter int unsigned opsz = OPSZ,
  parameter int unsigned prsz = 128,
  parameter int unsigned xlen = XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  iss_bundle_t [iwd-1:0]    iss_bundle,
  output logic [iwd-1:0]           issue,
  input  exe_bundle_t [iwd-1:0]    exe_bundle,
  input  red_bundle_t              red_bundle,
  input  logic [iwd-1:0]           fu_accept,
  output rr_bundle_t [iwd-1:0]     rr_bundle
);

  localparam int unsigned AW = $clog2(prsz);

  logic [2*iwd-1:0][AW-1:0]   raddr;
  logic [2*iwd-1:0][xlen-1:0] rdata;
  logic [iwd-1:0]             we;
  logic [iwd-1:0][AW-1:0]     waddr;
  logic [iwd-1:0][xlen-1:0]   wdata;
  logic [iwd-1:0][1:0]        hit;
  rr_bundle_t [iwd-1:0]       rr_q, rr_d;
  logic                       unused_exe;

  always_comb begin
    unused_exe = 1'b0;
    for (int w = 0; w < int'(iwd); w++) begin
      we[w]      = exe_bundle[w].opid[15];
      waddr[w]   = exe_bundle[w].prda[AW-1:0];
      wdata[w]   = exe_bundle[w].res;
      unused_exe = unused_exe ^ (^exe_bundle[w].opid[14:0]) ^ (^exe_bundle[w].prda);
    end
    for (int i = 0; i < int'(iwd); i++) begin
      raddr[2*i]   = iss_bundle[i].prsa[0][AW-1:0];
      raddr[2*i+1] = iss_bundle[i].prsa[1][AW-1:0];
    end
  end

  regread_prf #(
    .nrd   (2 * iwd),
    .nwr   (iwd),
    .depth (prsz),
    .width (xlen)
  ) u_prf (
    .clk   (clk),
    .rst   (rst),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  // Bypass hit per source: the value itself comes through the register file's
  // write-first path; here we only need to know a hit happened to clear prsb.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(iwd); i++) begin
      for (int k = 0; k < 2; k++) begin
        for (int w = 0; w < int'(iwd); w++) begin
          if (we[w] && (waddr[w] != '0) && (waddr[w] == raddr[2*i+k])) hit[i][k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_d  = rr_q;
    issue = '0;
    for (int i = 0; i < int'(iwd); i++) begin
      issue[i] = ~rr_q[i].opid[15] | fu_accept[i];
      if (iss_bundle[i].opid[15] && issue[i] &&
          !succeed(red_bundle, iss_bundle[i].opid, opsz)) begin
        rr_d[i].opid   = iss_bundle[i].opid;
        rr_d[i].uop    = iss_bundle[i].uop;
        rr_d[i].prsa   = iss_bundle[i].prsa;
        rr_d[i].prda   = iss_bundle[i].prda;
        rr_d[i].prsb   = iss_bundle[i].prsb & ~hit[i];
        rr_d[i].opa    = rdata[2*i];
        rr_d[i].opb    = rdata[2*i+1];
        // Not-ready opb means the memory FU treats this as address-only.
        rr_d[i].opb_ok = ~(iss_bundle[i].prsb[1] & ~hit[i][1]);
      end else if (rr_q[i].opid[15] &&
                   (fu_accept[i] || succeed(red_bundle, rr_q[i].opid, opsz))) begin
        rr_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end

  assign rr_bundle = rr_q;

endmodule

// File: tb/tb_regread.sv
// Directed self-checking bench for regread.
module tb_regread;
  import regread_pkg::*;

  logic                clk;
  logic                rst;
  iss_bundle_t [3:0]   iss;
  exe_bundle_t [3:0]   exe;
  red_bundle_t         red;
  logic [3:0]          fu_accept;
  logic [3:0]          issue;
  rr_bundle_t [3:0]    rr;

  int checks = 0;
  int errors = 0;

  regread dut (
    .clk        (clk),
    .rst        (rst),
    .iss_bundle (iss),
    .issue      (issue),
    .exe_bundle (exe),
    .red_bundle (red),
    .fu_accept  (fu_accept),
    .rr_bundle  (rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic iss_bundle_t mk_iss(input logic [5:0] id, input logic [7:0] a0,
                                         input logic [7:0] a1, input logic b0, input logic b1);
    iss_bundle_t op;
    op.opid    = 16'h8000 | {10'd0, id};
    op.uop     = {2'b00, id};
    op.prsa[0] = a0;
    op.prsa[1] = a1;
    op.prsb    = {b1, b0};
    op.prda    = 8'd40;
    return op;
  endfunction

  function automatic exe_bundle_t mk_exe(input logic [7:0] prda, input logic [63:0] res);
    exe_bundle_t e;
    e.opid = 16'h8000;
    e.prda = prda;
    e.res  = res;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    iss       = '0;
    exe       = '0;
    red       = '0;
    fu_accept = 4'hf;
    #1;
    chk("rst_rr_zero", 64'(rr == '0), 64'd1);
    chk("rst_issue", 64'(issue), 64'hf);
    @(posedge clk);
    #1;
    chk("rst_rr_hold", 64'(rr == '0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Fresh register file reads zero.
    iss[0] = mk_iss(6'd1, 8'd5, 8'd0, 1'b0, 1'b0);
    tick();
    chk("prf5_init_opid", 64'(rr[0].opid), 64'h8001);
    chk("prf5_init_opa", rr[0].opa, 64'h0);

    // Write r5, no capture: lane 0 drains.
    iss    = '0;
    exe[0] = mk_exe(8'd5, 64'hAB);
    tick();
    chk("drain_valid", 64'(rr[0].opid[15]), 64'd0);

    // Read r5 from the register file.
    exe    = '0;
    iss[0] = mk_iss(6'd2, 8'd5, 8'd0, 1'b0, 1'b0);
    tick();
    chk("rd5_opa", rr[0].opa, 64'hAB);
    chk("rd5_opb", rr[0].opb, 64'h0);
    chk("rd5_opb_ok", 64'(rr[0].opb_ok), 64'd1);

    // Same-cycle bypass, two writers to r9: lane 2 must win over lane 1.
    iss[0] = mk_iss(6'd3, 8'd9, 8'd0, 1'b1, 1'b0);
    exe[1] = mk_exe(8'd9, 64'h55);
    exe[2] = mk_exe(8'd9, 64'h77);
    tick();
    chk("byp_opa", rr[0].opa, 64'h77);
    chk("byp_prsb0", 64'(rr[0].prsb[0]), 64'd0);

    exe    = '0;
    iss[0] = mk_iss(6'd4, 8'd9, 8'd0, 1'b0, 1'b0);
    tick();
    chk("prf9_opa", rr[0].opa, 64'h77);

    // Lane 1 hold under back-pressure.
    iss          = '0;
    iss[1]       = mk_iss(6'd5, 8'd5, 8'd0, 1'b0, 1'b0);
    fu_accept[1] = 1'b0;
    tick();
    chk("hold_cap_opid", 64'(rr[1].opid), 64'h8005);
    chk("hold_issue", 64'(issue), 64'b1101);
    iss[1] = mk_iss(6'd6, 8'd9, 8'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_opid", 64'(rr[1].opid), 64'h8005);
      chk("hold_opa", rr[1].opa, 64'hAB);
      chk("hold_issue1", 64'(issue[1]), 64'd0);
    end
    fu_accept[1] = 1'b1;
    iss[1]       = mk_iss(6'd7, 8'd9, 8'd0, 1'b0, 1'b0);
    #1;
    chk("accept_issue1", 64'(issue[1]), 64'd1);
    tick();
    chk("nobubble_opid", 64'(rr[1].opid), 64'h8007);
    chk("nobubble_opa", rr[1].opa, 64'h77);

    // Load lanes 1..3 with opids 13, 20, 12.
    iss[1] = mk_iss(6'd13, 8'd0, 8'd0, 1'b0, 1'b0);
    iss[2] = mk_iss(6'd20, 8'd0, 8'd0, 1'b0, 1'b0);
    iss[3] = mk_iss(6'd12, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("load1", 64'(rr[1].opid), 64'h800D);
    chk("load2", 64'(rr[2].opid), 64'h8014);
    chk("load3", 64'(rr[3].opid), 64'h800C);

    // Redirect opid 12, topid 10.
    fu_accept = 4'b0001;
    iss       = '0;
    iss[0]    = mk_iss(6'd14, 8'd0, 8'd0, 1'b0, 1'b0);
    red.opid  = 16'h800C;
    red.topid = 16'd10;
    #1;
    chk("red_issue", 64'(issue), 64'b0001);
    tick();
    chk("red_drop13", 64'(rr[1].opid[15]), 64'd0);
    chk("red_drop20", 64'(rr[2].opid[15]), 64'd0);
    chk("red_keep12", 64'(rr[3].opid), 64'h800C);
    chk("red_nocap14", 64'(rr[0].opid[15]), 64'd0);

    // Store with unready data operand; write to r0 is ignored even same-cycle.
    red       = '0;
    fu_accept = 4'hf;
    iss[0]    = mk_iss(6'd15, 8'd9, 8'd33, 1'b0, 1'b1);
    iss[1]    = mk_iss(6'd17, 8'd0, 8'd0, 1'b0, 1'b0);
    exe[0]    = mk_exe(8'd0, 64'hFF);
    tick();
    chk("st_opb_ok", 64'(rr[0].opb_ok), 64'd0);
    chk("st_prsb1", 64'(rr[0].prsb[1]), 64'd1);
    chk("st_opa", rr[0].opa, 64'h77);
    chk("r0_byp_opa", rr[1].opa, 64'h0);
    chk("lane3_drain", 64'(rr[3].opid[15]), 64'd0);

    exe    = '0;
    iss    = '0;
    iss[0] = mk_iss(6'd16, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("r0_opa", rr[0].opa, 64'h0);
    chk("r0_opid", 64'(rr[0].opid), 64'h8010);

    iss = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regread.md
Name: regread

Overview:
- Register-read stage between the out-of-order issue queue and the function units.
- Accepts up to `iwd` issued micro-ops per cycle and reads source operands from the physical register file.
- Bypasses same-cycle writebacks into those operands and holds each result in a per-lane pipeline register until the consuming FU accepts it.
- Drives the per-lane `issue` back-pressure signal to the issue queue and drops micro-ops squashed by a redirect.

Parameters:
- iwd, 4, issue/read lanes
- opsz, 64, operation ID space; age compare uses $clog2(opsz) bits
- prsz, 128, physical register count
- xlen, 64, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-low
- iss_bundle  in  iwd x iss_bundle_t  issued micro-ops; lane valid = opid[15]
- issue  out  iwd  lane may accept an issued micro-op this cycle
- exe_bundle  in  iwd x exe_bundle_t  writebacks; valid = opid[15]; carries prda, res
- red_bundle  in  red_bundle_t  redirect; valid = opid[15]; carries opid, topid
- fu_accept  in  iwd  FU consumes lane output this cycle
- rr_bundle  out  iwd x rr_bundle_t  micro-op plus operand values opa/opb; valid = opid[15]

Behaviour:
- Reset (rst=0, asynchronous):
  - All lane valid bits clear; rr_bundle = 0; issue = all ones.
  - Register file contents are zero.
- Register file:
  - prsz x xlen, 2*iwd read ports, iwd write ports.
  - Written at the clock edge for every valid exe_bundle lane.
  - Register 0 always reads 0; writes to it are ignored.
- Handshake, lane i:
  - issue[i] = ~valid[i] | fu_accept[i], purely combinational.
  - Capture occurs when iss_bundle[i] is valid and issue[i]=1.
  - Latency is 1 cycle: capture at edge N, rr_bundle valid after edge N.
  - If fu_accept[i]=1 and no new capture, valid[i] clears.
  - While valid[i]=1 and fu_accept[i]=0, the lane holds all fields unchanged.
- Operand read at capture, for each source k:
  - Address is prsa[k].
  - Value priority: highest-index valid exe_bundle lane with prda == prsa[k] (bypass); otherwise register file.
  - A bypass hit also clears prsb[k] in the captured bundle.
  - If prsb[k] is still 1 after bypass, the operand is marked not-ready. This is legal only for the store data operand, k=1.
  - The memory FU treats a not-ready opb as address-only; the issue queue resends the op later.
- Flush:
  - succeed(x) is true when red_bundle is valid, x[15]=1, and, all modulo opsz, (x - topid) >= (red.opid - topid) + 1.
  - A held lane with succeed(opid) clears valid at the next edge regardless of fu_accept.
  - An incoming op with succeed(opid) is not captured.
  - The redirecting op itself survives.
  - During a redirect cycle, issue is still computed normally.
- Simultaneous events:
  - Writeback and read of the same register in one cycle: bypass wins.
  - Two writebacks to the same prda in one cycle: the higher lane writes and bypasses.
  - Accept and capture in the same cycle: the lane loads the new op; no bubble.
- Width rules:
  - prsa/prda are truncated to $clog2(prsz) bits for indexing.
  - opid compare uses $clog2(opsz)-bit wrap-around arithmetic.

Decomposition:
- Shared `types` package:
  - rr_bundle_t = iss_bundle_t fields plus opa, opb (xlen) and opb_ok.
  - Add field res to exe_bundle_t.
  - Constant XLEN.
- The succeed() age-compare function moves into the package so it is shared with the issue queue.
- Sub-module `prf`: a multi-port register file with write-first internal bypass and hardwired zero register.

Test Plan:
- Reset → rr_bundle all 0 and issue=4'b1111 while rst=0; prf[5] reads 0 after release.
- Write prda=5, res=0xAB, then issue an op with prsa={5,0} on lane 0 → next cycle rr_bundle[0].opa=0xAB, opb=0.
- Issue prsa[0]=9 while exe_bundle[2] writes prda=9, res=0x77 in the same cycle → opa=0x77 and prsb[0]=0; prf[9]=0x77 afterwards.
- Lane 1 valid with fu_accept[1]=0 for 3 cycles → issue[1]=0 and rr_bundle[1] stable; on accept plus a new issue in the same cycle → new op appears with no bubble.
- Redirect with topid=10, opid=12:
  - held ops with opid=13 and 20 drop;
  - held op with opid=12 stays;
  - incoming op with opid=14 is not captured.
- Store with prsb[1]=1 and no bypass → opb_ok=0 and opa valid; prda=0 writeback with res=0xFF → prf[0] still reads 0.
